// File: rtl/am_error_stats_pkg.sv
// Shared definitions for the approximate-multiplier error statistics block:
// default widths, saturation value and the control FSM state encoding.
package am_stats_pkg;

    localparam int W_DEFAULT     = 8;
    localparam int CNT_W_DEFAULT = 16;
    localparam int SUM_W_DEFAULT = 32;

    localparam logic [SUM_W_DEFAULT-1:0] SUM_SAT = {SUM_W_DEFAULT{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/am_error_stats_if.sv
// Sample stream and result port of am_error_stats.
// The master side is the evaluation harness, the slave side is the statistics block.
interface am_error_stats_if
    import am_stats_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int SUM_W = SUM_W_DEFAULT
);
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       x;
    logic [W-1:0]       y;
    logic [2*W-1:0]     z_approx;
    logic               res_valid;
    logic               res_ready;
    logic [CNT_W-1:0]   res_count;
    logic [CNT_W-1:0]   res_err_cnt;
    logic [SUM_W-1:0]   res_sum_ed;
    logic [2*W-1:0]     res_max_ed;
    logic               res_overflow;

    modport master (
        output in_valid, x, y, z_approx, res_ready,
        input  in_ready, res_valid, res_count, res_err_cnt, res_sum_ed, res_max_ed, res_overflow
    );

    modport slave (
        input  in_valid, x, y, z_approx, res_ready,
        output in_ready, res_valid, res_count, res_err_cnt, res_sum_ed, res_max_ed, res_overflow
    );
endinterface

// File: rtl/am_exact_diff.sv
// First pipeline stage: exact product of an accepted sample and its absolute
// distance from the approximate product, plus the stage-valid flag.
module am_exact_diff
    import am_stats_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic [2*W-1:0]   z_approx,
    output logic [2*W-1:0]   ed,
    output logic             valid
);

    logic [2*W-1:0]        p_s;
    logic signed [2*W:0]   diff_s;
    logic [2*W-1:0]        mag_s;

    // Exact product and magnitude of the signed difference; the magnitude always fits in 2W bits.
    always_comb begin
        p_s    = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        diff_s = $signed({1'b0, p_s}) - $signed({1'b0, z_approx});
        if (diff_s[2*W]) begin
            mag_s = ~diff_s[2*W-1:0] + {{(2*W-1){1'b0}}, 1'b1};
        end else begin
            mag_s = diff_s[2*W-1:0];
        end
    end

    // Stage register: capture the distance only for accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ed    <= {(2*W){1'b0}};
            valid <= 1'b0;
        end else begin
            valid <= accept;
            if (accept) begin
                ed <= mag_s;
            end
        end
    end

endmodule

// File: rtl/am_error_stats.sv
// Windowed error statistics for an approximate multiplier: counts samples and
// erroneous samples, sums (saturating) and maximises the error distance.
module am_error_stats
    import am_stats_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int SUM_W = SUM_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    am_error_stats_if.slave      bus
);

    localparam logic [SUM_W-1:0] SAT   = {SUM_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [CNT_W-1:0]   n_r;
    logic [CNT_W-1:0]   acc_cnt_r;
    logic               in_ready_r;
    logic               res_valid_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [SUM_W-1:0]   sum_r;
    logic [2*W-1:0]     max_r;
    logic               ovf_r;

    logic               accept_s;
    logic               start_ok_s;
    logic [2*W-1:0]     ed_s;
    logic               v1_s;
    logic [SUM_W:0]     sum_ext_s;

    assign accept_s   = bus.in_valid & in_ready_r;
    assign start_ok_s = start & (state_r == IDLE);
    // Requires SUM_W >= 2W so the distance zero-extends into the accumulator.
    assign sum_ext_s  = {1'b0, sum_r} + {{(SUM_W + 1 - 2*W){1'b0}}, ed_s};

    am_exact_diff #(.W(W)) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept_s),
        .x        (bus.x),
        .y        (bus.y),
        .z_approx (bus.z_approx),
        .ed       (ed_s),
        .valid    (v1_s)
    );

    // Window control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            n_r         <= {CNT_W{1'b0}};
            acc_cnt_r   <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        n_r       <= num_samples;
                        acc_cnt_r <= {CNT_W{1'b0}};
                        if (num_samples == {CNT_W{1'b0}}) begin
                            state_r     <= REPORT;
                            res_valid_r <= 1'b1;
                        end else begin
                            state_r    <= ACCUM;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_cnt_r <= acc_cnt_r + ONE_C;
                        if (acc_cnt_r + ONE_C == n_r) begin
                            state_r    <= DRAIN;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Once stage 1 is empty the accumulators hold the final values.
                    if (!v1_s) begin
                        state_r     <= REPORT;
                        res_valid_r <= 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2: accumulate statistics; cleared by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= {CNT_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
            sum_r     <= {SUM_W{1'b0}};
            max_r     <= {(2*W){1'b0}};
            ovf_r     <= 1'b0;
        end else if (start_ok_s) begin
            count_r   <= {CNT_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
            sum_r     <= {SUM_W{1'b0}};
            max_r     <= {(2*W){1'b0}};
            ovf_r     <= 1'b0;
        end else if (v1_s) begin
            count_r <= count_r + ONE_C;
            if (ed_s != {(2*W){1'b0}}) begin
                err_cnt_r <= err_cnt_r + ONE_C;
            end
            if (ed_s > max_r) begin
                max_r <= ed_s;
            end
            if (sum_ext_s[SUM_W]) begin
                sum_r <= SAT;
                ovf_r <= 1'b1;
            end else begin
                sum_r <= sum_ext_s[SUM_W-1:0];
            end
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.res_valid    = res_valid_r;
    assign bus.res_count    = count_r;
    assign bus.res_err_cnt  = err_cnt_r;
    assign bus.res_sum_ed   = sum_r;
    assign bus.res_max_ed   = max_r;
    assign bus.res_overflow = ovf_r;

endmodule

// File: tb/tb_am_error_stats.sv
// Directed bench for am_error_stats: two instances (32-bit and 16-bit sum) share
// stimulus; a reference model pushes expected window results to a scoreboard queue.
module tb_am_error_stats;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [7:0]  x, y;
    logic [15:0] z;
    logic        res_ready;

    always #5 clk = ~clk;

    am_error_stats_if #(.W(8), .CNT_W(16), .SUM_W(32)) ifa ();
    am_error_stats_if #(.W(8), .CNT_W(16), .SUM_W(16)) ifb ();

    assign ifa.in_valid = in_valid;
    assign ifa.x = x;
    assign ifa.y = y;
    assign ifa.z_approx = z;
    assign ifa.res_ready = res_ready;
    assign ifb.in_valid = in_valid;
    assign ifb.x = x;
    assign ifb.y = y;
    assign ifb.z_approx = z;
    assign ifb.res_ready = res_ready;

    am_error_stats #(.W(8), .CNT_W(16), .SUM_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(ifa.slave));
    am_error_stats #(.W(8), .CNT_W(16), .SUM_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(ifb.slave));

    typedef struct {
        longint cnt;
        longint err;
        longint sum32;
        longint ovf32;
        longint sum16;
        longint ovf16;
        longint max;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   m;
    int     n_cmp = 0;
    int     n_mis = 0;
    int     lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        m = '{cnt: 0, err: 0, sum32: 0, ovf32: 0, sum16: 0, ovf16: 0, max: 0};
    endtask

    task automatic model_add(input longint xa, input longint ya, input longint za);
        longint p, ed;
        p  = xa * ya;
        ed = (p >= za) ? p - za : za - p;
        m.cnt++;
        if (ed != 0) m.err++;
        if (ed > m.max) m.max = ed;
        m.sum32 += ed;
        if (m.sum32 > 64'd4294967295) begin m.sum32 = 64'd4294967295; m.ovf32 = 1; end
        m.sum16 += ed;
        if (m.sum16 > 64'd65535) begin m.sum16 = 64'd65535; m.ovf16 = 1; end
    endtask

    task automatic start_win(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        num_samples = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [7:0] xa, input logic [7:0] ya, input logic [15:0] za, input int gap);
        int t;
        @(negedge clk);
        x = xa; y = ya; z = za; in_valid = 1'b1;
        t = 0;
        while (!ifa.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_in_time", 64'(t < 20), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_add(longint'(xa), longint'(ya), longint'(za));
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_report(input int hold, output int lat_o);
        exp_t e;
        lat_o = 0;
        while (!ifa.res_valid && lat_o < 10) begin
            @(posedge clk);
            #1;
            lat_o++;
        end
        check("res_valid_timeout", 64'(ifa.res_valid), 64'd1);
        e = sb_q.pop_front();
        check("no_ready_in_report", 64'(ifa.in_ready), 64'd0);
        check("res_count", 64'(ifa.res_count), 64'(e.cnt));
        check("res_err_cnt", 64'(ifa.res_err_cnt), 64'(e.err));
        check("res_sum_ed", 64'(ifa.res_sum_ed), 64'(e.sum32));
        check("res_max_ed", 64'(ifa.res_max_ed), 64'(e.max));
        check("res_overflow", 64'(ifa.res_overflow), 64'(e.ovf32));
        check("res_sum_ed_16", 64'(ifb.res_sum_ed), 64'(e.sum16));
        check("res_overflow_16", 64'(ifb.res_overflow), 64'(e.ovf16));
        check("res_max_ed_16", 64'(ifb.res_max_ed), 64'(e.max));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(ifa.res_valid), 64'd1);
            check("hold_count", 64'(ifa.res_count), 64'(e.cnt));
            check("hold_sum", 64'(ifa.res_sum_ed), 64'(e.sum32));
            check("hold_max", 64'(ifa.res_max_ed), 64'(e.max));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("after_ack_valid", 64'(ifa.res_valid), 64'd0);
        check("after_ack_count", 64'(ifa.res_count), 64'(e.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = 16'd0; in_valid = 1'b0;
        x = 8'd0; y = 8'd0; z = 16'd0; res_ready = 1'b0;
        model_clear();
        #1;
        check("rst_in_ready", 64'(ifa.in_ready), 64'd0);
        check("rst_res_valid", 64'(ifa.res_valid), 64'd0);
        check("rst_res_count", 64'(ifa.res_count), 64'd0);
        check("rst_res_sum", 64'(ifa.res_sum_ed), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: exact window
        start_win(16'd3);
        send(8'd3, 8'd5, 16'd15, 0);
        send(8'd255, 8'd255, 16'hFE01, 0);
        send(8'd0, 8'd7, 16'd0, 0);
        sb_q.push_back(m);
        wait_report(0, lat);
        check("t1_latency_2to3", 64'(lat >= 2 && lat <= 3), 64'd1);

        // 2: error window, EDs 1, 256, 1
        start_win(16'd3);
        send(8'd255, 8'd255, 16'hFE00, 0);
        send(8'd16, 8'd16, 16'h0000, 0);
        send(8'd2, 8'd2, 16'd5, 0);
        sb_q.push_back(m);
        wait_report(0, lat);

        // 3: gaps, extra sample after the window, delayed res_ready
        start_win(16'd4);
        send(8'd10, 8'd10, 16'd90, 1);
        send(8'd7, 8'd9, 16'd63, 1);
        send(8'd200, 8'd3, 16'd700, 1);
        send(8'd12, 8'd12, 16'd150, 0);
        check("t3_ready_drop", 64'(ifa.in_ready), 64'd0);
        x = 8'd99; y = 8'd99; z = 16'd0; in_valid = 1'b1;
        sb_q.push_back(m);
        wait_report(5, lat);
        in_valid = 1'b0;

        // 4: zero window, then start ignored during ACCUM
        start_win(16'd0);
        sb_q.push_back(m);
        wait_report(0, lat);
        check("t4_zero_next_cycle", 64'(lat), 64'd0);
        start_win(16'd2);
        send(8'd3, 8'd3, 16'd8, 0);
        @(negedge clk);
        start = 1'b1; num_samples = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0; num_samples = 16'd2;
        send(8'd4, 8'd4, 16'd19, 0);
        sb_q.push_back(m);
        wait_report(0, lat);

        // 5: saturation of the 16-bit sum instance
        start_win(16'd2);
        send(8'd255, 8'd255, 16'd0, 0);
        send(8'd255, 8'd255, 16'd0, 0);
        sb_q.push_back(m);
        wait_report(0, lat);

        // 6: asynchronous reset mid-window
        start_win(16'd3);
        send(8'd1, 8'd2, 16'd3, 0);
        send(8'd1, 8'd2, 16'd3, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_in_ready", 64'(ifa.in_ready), 64'd0);
        check("t6_res_valid", 64'(ifa.res_valid), 64'd0);
        check("t6_res_count", 64'(ifa.res_count), 64'd0);
        check("t6_res_err_cnt", 64'(ifa.res_err_cnt), 64'd0);
        check("t6_res_sum", 64'(ifa.res_sum_ed), 64'd0);
        check("t6_res_max", 64'(ifa.res_max_ed), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_win(16'd1);
        send(8'd1, 8'd1, 16'd0, 0);
        sb_q.push_back(m);
        wait_report(0, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
